// File: rtl/exe_hazard_ctrl.sv
// exe_hazard_ctrl: hazard control for the JOF32 ID->EX->MEM->WB pipeline.
// It tracks the destination register of each in-flight instruction, detects
// load-use hazards and slow-memory holds, and registers the ALU forwarding
// selects for each instruction as it enters Execute.
module exe_hazard_ctrl #(
    parameter int NREG_W      = 4,
    parameter int ZERO_REG_HW = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [NREG_W-1:0] id_rs,
    input  logic [NREG_W-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [NREG_W-1:0] id_dest,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              mem_ready,
    output logic              stall_id,
    output logic              pipe_hold,
    output logic              ex_bubble,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [NREG_W-1:0] wb_dest,
    output logic              wb_write,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    // Slot contents beyond the valid bits; WB never needs the load flag.
    logic [NREG_W-1:0] ex_dest, mem_dest;
    logic              ex_wr, mem_wr, wb_wr;
    logic              ex_load, mem_load;

    logic              luh;
    logic              issue;
    logic [1:0]        fwd_a_next, fwd_b_next;

    // A slot feeds a source when it holds a live write to that register.
    // Register 0 is excluded when it is hard-wired.
    function automatic logic slot_match(
        input logic              v,
        input logic              w,
        input logic [NREG_W-1:0] d,
        input logic [NREG_W-1:0] src,
        input logic              used
    );
        logic src_zero;
        src_zero = (ZERO_REG_HW != 0) && (src == '0);
        return v && w && used && (d == src) && !src_zero;
    endfunction

    // Hazard detection, stall and bubble decisions from current slots and ID.
    always_comb begin
        pipe_hold = mem_valid && mem_load && !mem_ready;
        luh       = ex_valid && ex_load &&
                    (slot_match(ex_valid, ex_wr, ex_dest, id_rs, id_use_rs) ||
                     slot_match(ex_valid, ex_wr, ex_dest, id_rt, id_use_rt));
        stall_id  = id_valid && (luh || pipe_hold) && !flush;
        ex_bubble = !id_valid || luh || flush;
        issue     = id_valid && !luh && !flush;
        wb_write  = wb_valid && wb_wr && !pipe_hold;
    end

    // Forwarding selects for the ID instruction; the youngest producer wins.
    always_comb begin
        fwd_a_next = SEL_RF;
        fwd_b_next = SEL_RF;
        if (slot_match(ex_valid, ex_wr, ex_dest, id_rs, id_use_rs))
            fwd_a_next = SEL_EX;
        else if (slot_match(mem_valid, mem_wr, mem_dest, id_rs, id_use_rs))
            fwd_a_next = SEL_MEM;
        if (slot_match(ex_valid, ex_wr, ex_dest, id_rt, id_use_rt))
            fwd_b_next = SEL_EX;
        else if (slot_match(mem_valid, mem_wr, mem_dest, id_rt, id_use_rt))
            fwd_b_next = SEL_MEM;
    end

    // Slot advance: shift when memory is not holding; a flush during a hold
    // only kills the EX instruction and leaves everything else frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_dest   <= '0;
            ex_wr     <= 1'b0;
            ex_load   <= 1'b0;
            mem_valid <= 1'b0;
            mem_dest  <= '0;
            mem_wr    <= 1'b0;
            mem_load  <= 1'b0;
            wb_valid  <= 1'b0;
            wb_dest   <= '0;
            wb_wr     <= 1'b0;
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
        end else if (pipe_hold) begin
            if (flush)
                ex_valid <= 1'b0;
        end else begin
            wb_valid  <= mem_valid;
            wb_dest   <= mem_dest;
            wb_wr     <= mem_wr;
            mem_valid <= ex_valid;
            mem_dest  <= ex_dest;
            mem_wr    <= ex_wr;
            mem_load  <= ex_load;
            if (issue) begin
                ex_valid  <= 1'b1;
                ex_dest   <= id_dest;
                ex_wr     <= id_reg_write;
                ex_load   <= id_is_load;
                fwd_a_sel <= fwd_a_next;
                fwd_b_sel <= fwd_b_next;
            end else begin
                ex_valid  <= 1'b0;
                ex_dest   <= '0;
                ex_wr     <= 1'b0;
                ex_load   <= 1'b0;
                fwd_a_sel <= SEL_RF;
                fwd_b_sel <= SEL_RF;
            end
        end
    end

    // Saturating count of stalled decode cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall_id && (stall_cycles != '1))
            stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule
